// File: rtl/tiny_proc_sequencer.sv
// rtl/tiny_proc_sequencer.sv - program counter and load/fetch/exec phase sequencer for the tiny processor core
module tiny_proc_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              run,
  input  logic              step,
  input  logic              halt_insn,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              fetch_en,
  output logic              exec_en,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WAIT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] load_addr_nx;
  logic [CNT_W-1:0]  exec_cnt;
  logic [CNT_W-1:0]  exec_cnt_nx;
  logic              step_prev;
  logic              step_rise;
  logic              exec_last;

  assign step_rise = step & ~step_prev;
  assign exec_last = (exec_cnt == CNT_W'(EXEC_CYCLES - 1));
  assign state_dbg = state;

  // State, pc, load address, exec counter and step history; everything holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      load_addr <= '0;
      exec_cnt  <= '0;
      step_prev <= 1'b0;
    end else if (ena) begin
      state     <= state_nx;
      pc        <= pc_nx;
      load_addr <= load_addr_nx;
      exec_cnt  <= exec_cnt_nx;
      step_prev <= step;
    end
  end

  // Next-state logic and per-state strobes; strobes are qualified by ena so a frozen design issues nothing
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    load_addr_nx = load_addr;
    exec_cnt_nx  = exec_cnt;
    ld_ready     = 1'b0;
    imem_we      = 1'b0;
    fetch_en     = 1'b0;
    exec_en      = 1'b0;
    halted       = 1'b0;
    imem_addr    = pc;
    // write data is only driven in LOAD so the memory bus reads zero while idle or in reset
    imem_wdata   = '0;

    case (state)
      S_IDLE: begin
        if (load_req) begin
          state_nx     = S_LOAD;
          load_addr_nx = '0;
        end else if (run) begin
          state_nx = S_FETCH;
        end else begin
          state_nx = S_WAIT;
        end
      end

      S_LOAD: begin
        imem_addr  = load_addr;
        imem_wdata = ld_data;
        if (load_req) begin
          // ready drops with load_req so a byte offered on the exit cycle is never acknowledged
          ld_ready = ena;
          imem_we  = ena & ld_valid;
          if (ld_valid) begin
            load_addr_nx = load_addr + ADDR_W'(1);
          end
        end else begin
          state_nx = S_IDLE;
          pc_nx    = '0;
        end
      end

      S_FETCH: begin
        fetch_en    = ena;
        exec_cnt_nx = '0;
        state_nx    = S_EXEC;
      end

      S_EXEC: begin
        exec_en = ena;
        if (!exec_last) begin
          exec_cnt_nx = exec_cnt + CNT_W'(1);
        end else if (halt_insn) begin
          state_nx = S_HALT;
        end else begin
          pc_nx = br_taken ? br_target : pc + ADDR_W'(1);
          if (load_req) begin
            state_nx     = S_LOAD;
            load_addr_nx = '0;
          end else if (run) begin
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (load_req) begin
          state_nx     = S_LOAD;
          load_addr_nx = '0;
        end else if (run || step_rise) begin
          state_nx = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (load_req) begin
          state_nx     = S_LOAD;
          load_addr_nx = '0;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tiny_proc_sequencer.sv
// tb/tb_tiny_proc_sequencer.sv - scoreboard bench for tiny_proc_sequencer
module tb_tiny_proc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       load_req = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       halt_insn;
  logic       br_taken;
  logic [3:0] br_target = 4'd9;
  logic       imem_we;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       fetch_en;
  logic       exec_en;
  logic [3:0] pc;
  logic       halted;
  logic [2:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_fetch = -1;
  logic period_chk = 1'b0;

  logic       br_en = 1'b0;
  logic [3:0] br_pc = 4'd0;
  logic       halt_en = 1'b0;
  logic [3:0] halt_pc = 4'd0;

  logic [11:0] wr_q[$];
  logic [3:0]  fetch_q[$];

  tiny_proc_sequencer #(.ADDR_W(4), .DATA_W(8), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_req(load_req), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .run(run), .step(step), .halt_insn(halt_insn),
    .br_taken(br_taken), .br_target(br_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .fetch_en(fetch_en), .exec_en(exec_en), .pc(pc),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // datapath stand-in: raises branch/halt while the chosen pc executes
  assign br_taken  = br_en && exec_en && (pc == br_pc);
  assign halt_insn = halt_en && exec_en && (pc == halt_pc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_fetch(input int max);
    int n = 0;
    while (fetch_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check("fetch_drain", 32'(fetch_q.size()), 32'd0);
    fetch_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobes"}, 32'({ld_ready, imem_we, fetch_en, exec_en, halted}), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // scoreboard: every write and fetch the DUT issues must match the head of its queue
  always @(negedge clk) begin
    if (!period_chk) last_fetch = -1;
    if (rst_n) begin
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'({imem_addr, imem_wdata}), 32'hFFFF_FFFF);
        end else begin
          logic [11:0] e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(e[11:8]));
          check("wr_data", 32'(imem_wdata), 32'(e[7:0]));
        end
      end
      if (fetch_en) begin
        if (fetch_q.size() == 0) begin
          check("unexpected_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          logic [3:0] f;
          f = fetch_q.pop_front();
          check("fetch_addr", 32'(imem_addr), 32'(f));
        end
        if (period_chk && last_fetch >= 0) check("fetch_gap", 32'(cyc - last_fetch), 32'd3);
        last_fetch = cyc;
      end
    end
  end

  initial begin
    // async reset with pins toggling, checked before the first clock edge
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      {load_req, ld_valid, run, step, ena} = 5'($urandom);
      ld_data = 8'($urandom);
      tick();
      check_idle_outputs("rst_hold");
    end
    {load_req, ld_valid, run, step} = 4'd0;
    ena = 1'b1;
    ld_data = 8'h00;
    rst_n = 1'b1;

    // load three bytes with gaps, plus one offered while ena is low
    load_req = 1'b1;
    tick();
    check("load_state", 32'(state_dbg), 32'd1);
    check("load_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back({4'(i), 8'hA0 + 8'(i)});
      ld_valid = 1'b1;
      ld_data = 8'hA0 + 8'(i);
      tick();
      ld_valid = 1'b0;
      tick();
    end
    ena = 1'b0;
    ld_valid = 1'b1;
    ld_data = 8'hFF;
    #1 check("ena0_ready", 32'(ld_ready), 32'd0);
    tick();
    ena = 1'b1;
    ld_valid = 1'b0;
    check("wr_q_empty_a", 32'(wr_q.size()), 32'd0);
    load_req = 1'b0;
    tick();
    check("load_exit_state", 32'(state_dbg), 32'd0);
    check("load_exit_pc", 32'(pc), 32'd0);

    // 17 bytes: the last wraps onto address 0; a byte on the load_req fall is dropped
    load_req = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      wr_q.push_back({4'(i % 16), 8'h10 + 8'(i)});
      ld_valid = 1'b1;
      ld_data = 8'h10 + 8'(i);
      tick();
    end
    load_req = 1'b0;
    ld_data = 8'h77;
    tick();
    ld_valid = 1'b0;
    check("wr_q_empty_b", 32'(wr_q.size()), 32'd0);
    check("fall_state", 32'(state_dbg), 32'd0);
    check("fall_pc", 32'(pc), 32'd0);

    // free run through the whole address space, then a taken branch at pc 3
    for (int i = 0; i < 16; i++) fetch_q.push_back(4'(i));
    fetch_q.push_back(4'd0);
    period_chk = 1'b1;
    run = 1'b1;
    drain_fetch(200);
    br_en = 1'b1;
    br_pc = 4'd3;
    fetch_q.push_back(4'd1);
    fetch_q.push_back(4'd2);
    fetch_q.push_back(4'd3);
    fetch_q.push_back(4'd9);
    fetch_q.push_back(4'd10);
    drain_fetch(100);
    run = 1'b0;
    period_chk = 1'b0;
    br_en = 1'b0;
    repeat (3) tick();
    check("run_stop_state", 32'(state_dbg), 32'd4);
    check("run_stop_pc", 32'(pc), 32'd11);

    // step held high for five cycles executes exactly one instruction
    fetch_q.push_back(4'd11);
    step = 1'b1;
    tick();
    check("step_fetch_latency", 32'(fetch_en), 32'd1);
    repeat (4) tick();
    step = 1'b0;
    check("step_hold_state", 32'(state_dbg), 32'd4);
    check("step_hold_pc", 32'(pc), 32'd12);
    check("step_hold_q", 32'(fetch_q.size()), 32'd0);
    tick();

    // a step edge during EXEC is discarded
    fetch_q.push_back(4'd12);
    step = 1'b1;
    tick();
    check("step2_fetch", 32'(fetch_en), 32'd1);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    check("step_exec_ign_state", 32'(state_dbg), 32'd4);
    check("step_exec_ign_pc", 32'(pc), 32'd13);
    check("step_exec_ign_q", 32'(fetch_q.size()), 32'd0);

    // halt and branch together at pc 5: halt wins and pc stays
    br_en = 1'b1;
    br_pc = 4'd5;
    halt_en = 1'b1;
    halt_pc = 4'd5;
    for (int i = 13; i < 22; i++) fetch_q.push_back(4'(i % 16));
    period_chk = 1'b1;
    run = 1'b1;
    drain_fetch(100);
    run = 1'b0;
    period_chk = 1'b0;
    repeat (3) tick();
    check("halt_state", 32'(state_dbg), 32'd5);
    check("halt_pc", 32'(pc), 32'd5);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_strobes", 32'({fetch_en, exec_en}), 32'd0);
    br_en = 1'b0;
    halt_en = 1'b0;
    load_req = 1'b1;
    tick();
    check("halt_to_load_state", 32'(state_dbg), 32'd1);
    check("halt_to_load_flag", 32'(halted), 32'd0);
    load_req = 1'b0;
    tick();
    check("reload_pc", 32'(pc), 32'd0);

    // ena low in the middle of EXEC freezes the counter and pc
    fetch_q.push_back(4'd0);
    run = 1'b1;
    tick();
    tick();
    check("exec0_en", 32'(exec_en), 32'd1);
    ena = 1'b0;
    run = 1'b0;
    #1 check("ena0_exec_en", 32'(exec_en), 32'd0);
    repeat (3) tick();
    check("ena0_state", 32'(state_dbg), 32'd3);
    check("ena0_pc", 32'(pc), 32'd0);
    ena = 1'b1;
    #1 check("resume_exec0", 32'(exec_en), 32'd1);
    tick();
    check("resume_exec1_state", 32'(state_dbg), 32'd3);
    check("resume_exec1_en", 32'(exec_en), 32'd1);
    tick();
    check("resume_done_state", 32'(state_dbg), 32'd4);
    check("resume_done_pc", 32'(pc), 32'd1);

    // asynchronous reset in the middle of free run
    fetch_q.push_back(4'd1);
    fetch_q.push_back(4'd2);
    run = 1'b1;
    drain_fetch(50);
    check("pre_rst_exec", 32'(exec_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
